div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider; the responder end of the execute-stage divide interface.
- Execute stage drives operands, signedness and a start level, then holds the pipeline stalled until ready_o rises.
- Result is packed as {remainder, quotient} so that the execute stage writes HI = remainder and LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
DATA_W, 32, operand width; result_o is 2*DATA_W. Iteration count equals DATA_W.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with operands
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
start_i  input  1  level request; high = divide requested, low = release result
annul_i  input  1  cancel an in-flight divide (branch flush or exception)
result_o  output  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}
ready_o  output  1  result valid

Behaviour:
- Reset (rst == 0 at an edge):
  - state = FREE; result_o = 0; ready_o = 0; counter and internal registers cleared.
  - Reset overrides every other input, including in the middle of a divide.
- States: FREE, BYZERO, ON, END. Outputs are registered.
- FREE:
  - ready_o = 0 and result_o = 0.
  - On an edge with start_i = 1, annul_i = 0 and opdata2_i != 0: capture signed_div_i and the magnitudes of both operands, then go to ON with cnt = 0.
    - Magnitude = two's complement when signed_div_i = 1 and the operand MSB = 1.
    - Also record the original sign bits.
  - On an edge with start_i = 1, annul_i = 0 and opdata2_i == 0: go to BYZERO.
  - start_i = 1 with annul_i = 1 is ignored.
- BYZERO:
  - Next edge goes to END with result_o = 0 and ready_o = 1.
  - If annul_i = 1 on that edge, go to FREE instead.
- ON:
  - Keep a (DATA_W+1)-bit partial remainder and a DATA_W-bit quotient shift register.
  - Each edge with annul_i = 0 performs one iteration:
    - shift {rem, dividend} left by 1;
    - trial-subtract the divisor;
    - if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0;
    - cnt++.
  - Iterations occur on edges E1..E32, where E0 is the start edge.
  - Edge E33 (cnt == DATA_W) finalizes and enters END with ready_o = 1.
  - ready_o is first high after edge E33: a latency of 33 cycles from the sampled start.
  - Sign correction (signed only):
    - quotient is negated if the dividend and divisor signs differ;
    - remainder is negated if the dividend is negative (remainder takes the dividend's sign).
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0. No trap.
  - annul_i = 1 on any ON edge: go to FREE, ready_o stays 0, partial result discarded.
  - start_i and operand changes during ON are ignored, because operands were captured at E0.
- END:
  - ready_o = 1; result_o is held stable.
  - annul_i has no effect.
  - On an edge with start_i = 0: go to FREE, ready_o = 0, result_o = 0.
  - While start_i stays 1, remain in END. A back-to-back divide requires start_i to drop for at least one cycle.
- Counter width: clog2(DATA_W)+1 bits. The counter never wraps: it stops at DATA_W and is cleared on entering ON.
- No combinational path from any input to any output.

Test Plan:
1. Unsigned: opdata1 = 100, opdata2 = 7, signed = 0, start held -> ready_o rises exactly 33 cycles after the start edge; result_o = 0x00000002_0000000E. Drop start -> next edge gives ready_o = 0, result_o = 0.
2. Signed: -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
3. Divide by zero: 5 / 0 -> ready_o high after the 2nd edge from start, result_o = 0. Same for the signed case.
4. Annul: start 1000 / 3, assert annul_i for one cycle at E10 -> FREE, ready_o never rises. A new start of 9 / 3 then gives result 0x00000000_00000003 at the normal latency.
5. Reset mid-divide: rst = 0 at E15 -> ready_o = 0, result_o = 0, state FREE. After rst returns high, a divide of 0xFFFFFFFF / 1 (unsigned) gives quotient 0xFFFFFFFF, remainder 0.
6. Boundaries:
   - signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0;
   - unsigned 3 / 0xFFFFFFFF -> quotient 0, remainder 3;
   - start held high in END for 5 cycles -> result stable and no restart.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for the execute stage.
// The requester raises start_i with operands and stalls until ready_o; the result
// is packed as {remainder, quotient} so the remainder lands in HI and the quotient in LO.
// Handshake: start_i is a level. The unit captures operands on the first edge it
// sees start_i high (annul_i low) in FREE, raises ready_o when the result is valid,
// holds the result while start_i stays high, and returns to idle on the first edge
// with start_i low. annul_i cancels anything not yet finished.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic [1:0]            state_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [DATA_W:0]     rem_q, rem_n;      // partial remainder
    logic [DATA_W-1:0]   dvd_q, dvd_n;      // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]   dvs_q, dvs_n;      // divisor magnitude
    logic                sgn_q, sgn_n;      // signed divide requested
    logic                s1_q, s1_n;        // original dividend sign
    logic                s2_q, s2_n;        // original divisor sign
    logic [2*DATA_W-1:0] result_n;
    logic                ready_n;

    // Datapath helpers for one restoring iteration and the final sign fix-up.
    logic [DATA_W+1:0]   shifted;
    logic [DATA_W+1:0]   diff;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign state_o = state_q;

    // Next-state, iteration datapath and registered-output values.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        rem_n    = rem_q;
        dvd_n    = dvd_q;
        dvs_n    = dvs_q;
        sgn_n    = sgn_q;
        s1_n     = s1_q;
        s2_n     = s2_q;
        result_n = result_o;
        ready_n  = ready_o;

        shifted  = {rem_q, dvd_q[DATA_W-1]};
        diff     = shifted - {2'b00, dvs_q};
        quo_fix  = (sgn_q && (s1_q ^ s2_q)) ? -dvd_q : dvd_q;
        rem_fix  = (sgn_q && s1_q) ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];

        unique case (state_q)
            ST_FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = ST_BYZERO;
                    end else begin
                        state_n = ST_ON;
                        cnt_n   = '0;
                        rem_n   = '0;
                        sgn_n   = signed_div_i;
                        s1_n    = opdata1_i[DATA_W-1];
                        s2_n    = opdata2_i[DATA_W-1];
                        dvd_n   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
                        dvs_n   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
                    end
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_n = ST_FREE;
                end else begin
                    state_n  = ST_END;
                    result_n = '0;
                    ready_n  = 1'b1;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_n  = ST_FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_n  = ST_END;
                    result_n = {rem_fix, quo_fix};
                    ready_n  = 1'b1;
                end else begin
                    // Restoring step: keep the difference only if it did not go negative.
                    if (!diff[DATA_W+1]) begin
                        rem_n = diff[DATA_W:0];
                        dvd_n = {dvd_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_n = shifted[DATA_W:0];
                        dvd_n = {dvd_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_n  = ST_FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_FREE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            rem_q    <= rem_n;
            dvd_q    <= dvd_n;
            dvs_q    <= dvs_n;
            sgn_q    <= sgn_n;
            s1_q     <= s1_n;
            s2_q     <= s2_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit latency, results, annul, reset and END hold.
module tb_div_unit;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BYZERO = 2'd1;
    localparam logic [1:0] ST_END    = 2'd3;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .state_o      (state_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a divide, scramble the operand inputs after the start edge, and wait
    // for ready_o. exp_edges counts rising edges from the start edge inclusive.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int exp_edges, input logic [63:0] exp_res);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            if (n == 0) begin
                opdata1_i    = 32'hFFFF_FFFF;
                opdata2_i    = 32'h0;
                signed_div_i = ~sgn;
            end
            n++;
            got = ready_o;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_edges));
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_state"}, 64'(state_o), 64'(ST_END));
    endtask

    task automatic release_div(input string tag);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_rel_result"}, result_o, 64'd0);
        check({tag, "_rel_state"}, 64'(state_o), 64'(ST_FREE));
    endtask

    initial begin
        int ready_seen;
        logic [63:0] held;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'(state_o), 64'(ST_FREE));
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b1;

        // Unsigned and signed basics
        run_div("u100_7", 32'd100, 32'd7, 1'b0, 34, 64'h00000002_0000000E);
        release_div("u100_7");
        run_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34, 64'hFFFFFFFF_FFFFFFFD);
        release_div("s_m7_2");
        run_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 34, 64'h00000001_FFFFFFFD);
        release_div("s_7_m2");
        run_div("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 34, 64'hFFFFFFFE_0000000E);
        release_div("s_m100_m7");
        run_div("u_max_16", 32'hFFFF_FFFF, 32'd16, 1'b0, 34, 64'h0000000F_0FFFFFFF);
        release_div("u_max_16");

        // Divide by zero
        run_div("u_div0", 32'd5, 32'd0, 1'b0, 2, 64'd0);
        release_div("u_div0");
        run_div("s_div0", 32'hFFFF_FFFB, 32'd0, 1'b1, 2, 64'd0);
        release_div("s_div0");

        // Annul while waiting in BYZERO
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        check("byzero_state", 64'(state_o), 64'(ST_BYZERO));
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("byzero_annul_state", 64'(state_o), 64'(ST_FREE));
        check("byzero_annul_ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;

        // Annul at E10 of 1000 / 3
        @(negedge clk);
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul_state", 64'(state_o), 64'(ST_FREE));
        check("annul_ready", 64'(ready_o), 64'd0);
        ready_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) ready_seen++;
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, 34, 64'h00000000_00000003);
        release_div("after_annul_9_3");

        // Reset at E15
        @(negedge clk);
        opdata1_i = 32'd12345;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_state", 64'(state_o), 64'(ST_FREE));
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 34, 64'h00000000_FFFFFFFF);
        release_div("u_max_1");

        // Boundaries
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 64'h00000000_80000000);
        release_div("s_ovf");
        run_div("u_3_max", 32'd3, 32'hFFFF_FFFF, 1'b0, 34, 64'h00000003_00000000);
        held    = result_o;
        annul_i = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_result", result_o, held);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_state", 64'(state_o), 64'(ST_END));
        end
        annul_i = 1'b0;
        release_div("u_3_max");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
